// File: rtl/ddr_resp_pkg.sv
// Shared types and constants for the DDR FIFO responder.
// The optional random back-pressure uses the LFSR constants below (DDR_RESP_RANDOM_STALL_EN).
package ddr_resp_pkg;

  localparam int BEAT_W = 128;
  localparam int MASK_W = 16;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // x^16 + x^14 + x^13 + x^11 + 1 as a mask over bits [15], [13], [12], [10]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_RD0,
    ST_RD1,
    ST_RD2
  } resp_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/resp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes while full and pops while empty are ignored.
// Handshake: an entry moves in when i_push is high and count < DEPTH, out when i_pop is high and count > 0.
module resp_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full FIFO drops the push even when a pop frees a slot in the same cycle.
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ddr_fifo_responder.sv
// Block-RAM stand-in for the DDR2 controller's address/write/read FIFO interface.
// Define DDR_RESP_RANDOM_STALL_EN to add LFSR-driven back-pressure on the push side.
module ddr_fifo_responder
  import ddr_resp_pkg::*;
#(
  parameter int MEM_ADDR_W = 10,
  parameter int AF_DEPTH   = 4,
  parameter int WDF_DEPTH  = 8,
  parameter int RDF_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              af_wr_en,
  input  logic [2:0]        af_cmd_din,
  input  logic [30:0]       af_addr_din,
  output logic              af_full,
  input  logic              wdf_wr_en,
  input  logic [BEAT_W-1:0] wdf_din,
  input  logic [MASK_W-1:0] wdf_mask_din,
  output logic              wdf_full,
  input  logic              rdf_rd_en,
  output logic              rdf_valid,
  output logic [BEAT_W-1:0] rdf_dout
);

  localparam int AF_CW  = $clog2(AF_DEPTH) + 1;
  localparam int WDF_CW = $clog2(WDF_DEPTH) + 1;
  localparam int RDF_CW = $clog2(RDF_DEPTH) + 1;
  localparam int MEM_N  = 2 ** MEM_ADDR_W;

  resp_state_e           r_state;
  logic [MEM_ADDR_W-1:0] r_idx;
  logic [BEAT_W-1:0]     r_mem_lo [MEM_N];
  logic [BEAT_W-1:0]     r_mem_hi [MEM_N];
  logic [BEAT_W-1:0]     r_rd_lo;
  logic [BEAT_W-1:0]     r_rd_hi;

  logic                  w_stall;
  logic                  w_af_push, w_af_pop;
  logic [33:0]           w_af_head;
  logic [AF_CW-1:0]      w_af_count;
  logic                  w_wdf_push, w_wdf_pop;
  logic [BEAT_W+MASK_W-1:0] w_wdf_head;
  logic [WDF_CW-1:0]     w_wdf_count;
  logic                  w_rdf_push;
  logic [BEAT_W-1:0]     w_rdf_din;
  logic [BEAT_W-1:0]     w_rdf_head;
  logic [RDF_CW-1:0]     w_rdf_count;

  logic [2:0]            w_head_cmd;
  logic [MEM_ADDR_W-1:0] w_head_idx;
  logic                  w_head_ok;
  logic                  w_go_wr, w_go_rd, w_drop;
  logic [BEAT_W-1:0]     w_beat;
  logic [MASK_W-1:0]     w_mask;
  logic                  w_unused_addr;

`ifdef DDR_RESP_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  assign w_af_push  = af_wr_en & ~w_stall;
  assign w_wdf_push = wdf_wr_en & ~w_stall;

  resp_sync_fifo #(.W(34), .DEPTH(AF_DEPTH)) u_af (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_af_push), .i_din({af_cmd_din, af_addr_din}),
    .i_pop(w_af_pop), .o_dout(w_af_head), .o_count(w_af_count)
  );

  resp_sync_fifo #(.W(BEAT_W + MASK_W), .DEPTH(WDF_DEPTH)) u_wdf (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_wdf_push), .i_din({wdf_mask_din, wdf_din}),
    .i_pop(w_wdf_pop), .o_dout(w_wdf_head), .o_count(w_wdf_count)
  );

  resp_sync_fifo #(.W(BEAT_W), .DEPTH(RDF_DEPTH)) u_rdf (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_rdf_push), .i_din(w_rdf_din),
    .i_pop(rdf_rd_en), .o_dout(w_rdf_head), .o_count(w_rdf_count)
  );

  assign w_head_cmd    = w_af_head[33:31];
  assign w_head_idx    = w_af_head[MEM_ADDR_W+1:2];
  assign w_unused_addr = ^{w_af_head[30:MEM_ADDR_W+2], w_af_head[1:0]};
  assign w_beat        = w_wdf_head[BEAT_W-1:0];
  assign w_mask        = w_wdf_head[BEAT_W+MASK_W-1:BEAT_W];

  // Read acceptance needs both beats' worth of room: one burst in flight at a time.
  assign w_head_ok = (r_state == ST_IDLE) && (w_af_count != '0) && !w_stall;
  assign w_go_wr   = w_head_ok && (w_head_cmd == CMD_WRITE) && (w_wdf_count >= WDF_CW'(2));
  assign w_go_rd   = w_head_ok && (w_head_cmd == CMD_READ)
                     && ((RDF_CW'(RDF_DEPTH) - w_rdf_count) >= RDF_CW'(2));
  assign w_drop    = w_head_ok && (w_head_cmd != CMD_WRITE) && (w_head_cmd != CMD_READ);

  assign w_af_pop   = w_go_wr | w_go_rd | w_drop;
  assign w_wdf_pop  = (r_state == ST_WR0) || (r_state == ST_WR1);
  assign w_rdf_push = (r_state == ST_RD1) || (r_state == ST_RD2);
  assign w_rdf_din  = (r_state == ST_RD1) ? r_rd_lo : r_rd_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go_wr) begin
            r_idx   <= w_head_idx;
            r_state <= ST_WR0;
          end else if (w_go_rd) begin
            r_idx   <= w_head_idx;
            r_state <= ST_RD0;
          end
        end
        ST_WR0:  r_state <= ST_WR1;
        ST_WR1:  r_state <= ST_IDLE;
        ST_RD0:  r_state <= ST_RD1;
        ST_RD1:  r_state <= ST_RD2;
        ST_RD2:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory is deliberately not reset; a reset in WR1 leaves LO written and HI untouched.
  always_ff @(posedge clk) begin
    if (r_state == ST_WR0) begin
      for (int b = 0; b < MASK_W; b++)
        if (!w_mask[b]) r_mem_lo[r_idx][8*b +: 8] <= w_beat[8*b +: 8];
    end
    if (r_state == ST_WR1) begin
      for (int b = 0; b < MASK_W; b++)
        if (!w_mask[b]) r_mem_hi[r_idx][8*b +: 8] <= w_beat[8*b +: 8];
    end
    if (r_state == ST_RD0) begin
      r_rd_lo <= r_mem_lo[r_idx];
      r_rd_hi <= r_mem_hi[r_idx];
    end
  end

  assign af_full   = (w_af_count == AF_CW'(AF_DEPTH)) | w_stall;
  assign wdf_full  = (w_wdf_count == WDF_CW'(WDF_DEPTH)) | w_stall;
  assign rdf_valid = (w_rdf_count != '0);
  assign rdf_dout  = rdf_valid ? w_rdf_head : '0;

endmodule

// File: tb/tb_ddr_fifo_responder.sv
// Directed self-checking bench for ddr_fifo_responder in its default build.
module tb_ddr_fifo_responder;

  localparam logic [2:0] CMD_WR  = 3'b000;
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_BAD = 3'b111;

  logic         clk;
  logic         rst_n;
  logic         af_wr_en;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         af_full;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_full;
  logic         rdf_rd_en;
  logic         rdf_valid;
  logic [127:0] rdf_dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] d1, d2, d3, lo_masked;
  logic [127:0] exp_q[$];

  ddr_fifo_responder dut (
    .clk(clk), .rst_n(rst_n),
    .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_full(af_full),
    .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_full(wdf_full),
    .rdf_rd_en(rdf_rd_en), .rdf_valid(rdf_valid), .rdf_dout(rdf_dout)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- drivers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] bv(input int i);
    logic [7:0] b;
    b = 8'h40 + 8'(i);
    return {16{b}};
  endfunction

  task automatic push_cmd(input logic [2:0] c, input logic [30:0] a);
    int n = 0;
    while (af_full && n < 50) begin tick(); n++; end
    if (af_full) begin
      n_cmp++; n_err++;
      $display("FAIL push_cmd_wait: af_full=%b required 0", af_full);
    end
    af_wr_en = 1'b1; af_cmd_din = c; af_addr_din = a;
    tick();
    af_wr_en = 1'b0;
  endtask

  task automatic push_beat(input logic [127:0] d, input logic [15:0] m);
    int n = 0;
    while (wdf_full && n < 50) begin tick(); n++; end
    if (wdf_full) begin
      n_cmp++; n_err++;
      $display("FAIL push_beat_wait: wdf_full=%b required 0", wdf_full);
    end
    wdf_wr_en = 1'b1; wdf_din = d; wdf_mask_din = m;
    tick();
    wdf_wr_en = 1'b0;
  endtask

  task automatic get_beat(output logic [127:0] b);
    int n = 0;
    while (!rdf_valid && n < 50) begin tick(); n++; end
    if (!rdf_valid) begin
      n_cmp++; n_err++;
      $display("FAIL get_beat_wait: rdf_valid=%b required 1", rdf_valid);
      b = 'x;
    end else begin
      b = rdf_dout;
      rdf_rd_en = 1'b1;
      tick();
      rdf_rd_en = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [30:0] a, output logic [127:0] lo, output logic [127:0] hi);
    push_cmd(CMD_RD, a);
    get_beat(lo);
    get_beat(hi);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (af_full !== 1'b0)      begin n_err++; $display("FAIL rst_af_full: got %b want 0", af_full); end
    n_cmp++; if (wdf_full !== 1'b0)     begin n_err++; $display("FAIL rst_wdf_full: got %b want 0", wdf_full); end
    n_cmp++; if (rdf_valid !== 1'b0)    begin n_err++; $display("FAIL rst_rdf_valid: got %b want 0", rdf_valid); end
    n_cmp++; if (rdf_dout !== 128'h0)   begin n_err++; $display("FAIL rst_rdf_dout: got %h want 0", rdf_dout); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_write_read();
    push_beat(d1, 16'h0);
    push_beat(d2, 16'h0);
    push_cmd(CMD_WR, 31'h8);
    repeat (6) tick();
    push_cmd(CMD_RD, 31'h8);
    tick();
    n_cmp++; if (rdf_valid !== 1'b0) begin n_err++; $display("FAIL lat_t2_valid: got %b want 0", rdf_valid); end
    tick();
    n_cmp++; if (rdf_valid !== 1'b0) begin n_err++; $display("FAIL lat_t3_valid: got %b want 0", rdf_valid); end
    tick();
    n_cmp++; if (rdf_valid !== 1'b1) begin n_err++; $display("FAIL lat_t4_valid: got %b want 1", rdf_valid); end
    n_cmp++; if (rdf_dout !== d1)    begin n_err++; $display("FAIL lat_t4_data: got %h want %h", rdf_dout, d1); end
    rdf_rd_en = 1'b1;
    tick();
    n_cmp++; if (rdf_valid !== 1'b1) begin n_err++; $display("FAIL lat_t5_valid: got %b want 1", rdf_valid); end
    n_cmp++; if (rdf_dout !== d2)    begin n_err++; $display("FAIL lat_t5_data: got %h want %h", rdf_dout, d2); end
    tick();
    rdf_rd_en = 1'b0;
    n_cmp++; if (rdf_valid !== 1'b0)  begin n_err++; $display("FAIL drain_valid: got %b want 0", rdf_valid); end
    n_cmp++; if (rdf_dout !== 128'h0) begin n_err++; $display("FAIL drain_dout: got %h want 0", rdf_dout); end
  endtask

  task automatic test_masked_write();
    logic [127:0] lo, hi;
    push_beat(128'hAB, 16'hFFFE);
    push_beat(d3, 16'h0);
    push_cmd(CMD_WR, 31'h8);
    read_burst(31'h8, lo, hi);
    n_cmp++; if (lo !== lo_masked) begin n_err++; $display("FAIL mask_lo: got %h want %h", lo, lo_masked); end
    n_cmp++; if (hi !== d3)        begin n_err++; $display("FAIL mask_hi: got %h want %h", hi, d3); end
  endtask

  task automatic test_af_full();
    logic [127:0] lo, hi;
    for (int k = 0; k < 4; k++) push_cmd(CMD_WR, 31'h10 + 31'(4 * k));
    n_cmp++; if (af_full !== 1'b1) begin n_err++; $display("FAIL af_full_4: got %b want 1", af_full); end
    af_wr_en = 1'b1; af_cmd_din = CMD_RD; af_addr_din = 31'h10;
    tick();
    af_wr_en = 1'b0;
    n_cmp++; if (af_full !== 1'b1) begin n_err++; $display("FAIL af_full_5th: got %b want 1", af_full); end
    for (int i = 0; i < 8; i++) push_beat(bv(i), 16'h0);
    repeat (20) tick();
    n_cmp++; if (af_full !== 1'b0)   begin n_err++; $display("FAIL af_drained: got %b want 0", af_full); end
    n_cmp++; if (rdf_valid !== 1'b0) begin n_err++; $display("FAIL af_5th_dropped: rdf_valid got %b want 0", rdf_valid); end
    for (int k = 0; k < 4; k++) begin
      read_burst(31'h10 + 31'(4 * k), lo, hi);
      n_cmp++; if (lo !== bv(2*k))   begin n_err++; $display("FAIL af_order_lo%0d: got %h want %h", k, lo, bv(2*k)); end
      n_cmp++; if (hi !== bv(2*k+1)) begin n_err++; $display("FAIL af_order_hi%0d: got %h want %h", k, hi, bv(2*k+1)); end
    end
  endtask

  task automatic test_rdf_backpressure();
    logic [127:0] b, e;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      push_cmd(CMD_RD, 31'h10 + 31'(4 * k));
      exp_q.push_back(bv(2*k));
      exp_q.push_back(bv(2*k+1));
    end
    push_cmd(CMD_RD, 31'h8);
    exp_q.push_back(lo_masked);
    exp_q.push_back(d3);
    repeat (30) tick();
    n_cmp++; if (rdf_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", rdf_valid); end
    n_cmp++; if (rdf_dout !== bv(0)) begin n_err++; $display("FAIL bp_head: got %h want %h", rdf_dout, bv(0)); end
    n_cmp++; if (af_full !== 1'b0)   begin n_err++; $display("FAIL bp_af_full: got %b want 0", af_full); end
    for (int i = 0; i < 10; i++) begin
      get_beat(b);
      e = exp_q.pop_front();
      n_cmp++; if (b !== e) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, b, e); end
    end
    tick();
    n_cmp++; if (rdf_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", rdf_valid); end
  endtask

  task automatic test_illegal_cmd();
    logic [127:0] lo, hi;
    push_cmd(CMD_BAD, 31'h8);
    read_burst(31'h8, lo, hi);
    n_cmp++; if (lo !== lo_masked) begin n_err++; $display("FAIL illegal_lo: got %h want %h", lo, lo_masked); end
    n_cmp++; if (hi !== d3)        begin n_err++; $display("FAIL illegal_hi: got %h want %h", hi, d3); end
    repeat (5) tick();
    n_cmp++; if (rdf_valid !== 1'b0) begin n_err++; $display("FAIL illegal_extra: rdf_valid got %b want 0", rdf_valid); end
  endtask

  task automatic test_wdf_full();
    logic [127:0] lo, hi;
    for (int i = 0; i < 7; i++) push_beat(bv(16 + i), 16'h0);
    n_cmp++; if (wdf_full !== 1'b0) begin n_err++; $display("FAIL wdf_full_7: got %b want 0", wdf_full); end
    push_beat(bv(23), 16'h0);
    n_cmp++; if (wdf_full !== 1'b1) begin n_err++; $display("FAIL wdf_full_8: got %b want 1", wdf_full); end
    wdf_wr_en = 1'b1; wdf_din = bv(30); wdf_mask_din = 16'h0;
    tick();
    wdf_wr_en = 1'b0;
    for (int k = 0; k < 4; k++) push_cmd(CMD_WR, 31'h20 + 31'(4 * k));
    push_beat(bv(40), 16'h0);
    push_beat(bv(41), 16'h0);
    push_cmd(CMD_WR, 31'h30);
    read_burst(31'h2C, lo, hi);
    n_cmp++; if (lo !== bv(22)) begin n_err++; $display("FAIL wdf_last_lo: got %h want %h", lo, bv(22)); end
    n_cmp++; if (hi !== bv(23)) begin n_err++; $display("FAIL wdf_last_hi: got %h want %h", hi, bv(23)); end
    read_burst(31'h30, lo, hi);
    n_cmp++; if (lo !== bv(40)) begin n_err++; $display("FAIL wdf_9th_dropped_lo: got %h want %h", lo, bv(40)); end
    n_cmp++; if (hi !== bv(41)) begin n_err++; $display("FAIL wdf_9th_dropped_hi: got %h want %h", hi, bv(41)); end
  endtask

  task automatic test_reset_mid_burst();
    logic [127:0] lo, hi;
    repeat (5) tick();
    push_beat(bv(50), 16'h0);
    push_beat(bv(51), 16'h0);
    push_beat(bv(52), 16'h0);
    push_cmd(CMD_WR, 31'h10);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (af_full !== 1'b0)    begin n_err++; $display("FAIL mid_rst_af_full: got %b want 0", af_full); end
    n_cmp++; if (wdf_full !== 1'b0)   begin n_err++; $display("FAIL mid_rst_wdf_full: got %b want 0", wdf_full); end
    n_cmp++; if (rdf_valid !== 1'b0)  begin n_err++; $display("FAIL mid_rst_rdf_valid: got %b want 0", rdf_valid); end
    n_cmp++; if (rdf_dout !== 128'h0) begin n_err++; $display("FAIL mid_rst_rdf_dout: got %h want 0", rdf_dout); end
    tick();
    rst_n = 1'b1;
    tick();
    push_beat(bv(60), 16'h0);
    push_beat(bv(61), 16'h0);
    push_cmd(CMD_WR, 31'h18);
    read_burst(31'h18, lo, hi);
    n_cmp++; if (lo !== bv(60)) begin n_err++; $display("FAIL flush_lo: got %h want %h", lo, bv(60)); end
    n_cmp++; if (hi !== bv(61)) begin n_err++; $display("FAIL flush_hi: got %h want %h", hi, bv(61)); end
    read_burst(31'h10, lo, hi);
    n_cmp++; if (lo !== bv(50)) begin n_err++; $display("FAIL abort_lo_new: got %h want %h", lo, bv(50)); end
    n_cmp++; if (hi !== bv(1))  begin n_err++; $display("FAIL abort_hi_old: got %h want %h", hi, bv(1)); end
  endtask

  // ---- sequence and report ----
  initial begin
    rst_n = 1'b0;
    af_wr_en = 1'b0; af_cmd_din = 3'b000; af_addr_din = '0;
    wdf_wr_en = 1'b0; wdf_din = '0; wdf_mask_din = '0;
    rdf_rd_en = 1'b0;
    d1 = {16{8'h11}};
    d2 = {16{8'h22}};
    d3 = {16{8'h33}};
    lo_masked = d1;
    lo_masked[7:0] = 8'hAB;

    test_reset();
    test_write_read();
    test_masked_write();
    test_af_full();
    test_rdf_backpressure();
    test_illegal_cmd();
    test_wdf_full();
    test_reset_mid_burst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
